// File: rtl/fnd_capture.sv
// ---------------------------------------------------------------------------
// fnd_capture
//
// Receive-side monitor for a 4-digit multiplexed 7-segment (FND) bus. It
// waits for the digit strobe and segment pattern to hold still, decodes each
// settled pattern back to BCD, and reassembles a 16-bit BCD frame once all
// four digits of a scan have been seen.
//
// Ports:
//   CLK            system clock
//   RESET          asynchronous, active-high reset
//   FND_COM[3:0]   one-hot digit strobe (1000 = thousands ... 0001 = units)
//   FND_DATA[7:0]  active-low segments, bit7 = a ... bit1 = g, bit0 = dp
//   VALUE[15:0]    last complete BCD frame, [15:12] thousands ... [3:0] units
//   VALUE_VALID    one-cycle pulse when VALUE is updated
//   VALUE_CHANGED  one-cycle pulse with VALUE_VALID when the frame differs
//   PAT_ERR        one-cycle pulse on capture of a non-decodable pattern
//   STALE          level, high after TIMEOUT cycles with no strobed capture
// ---------------------------------------------------------------------------
module fnd_capture #(
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 1048576
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  FND_COM,
    input  logic [7:0]  FND_DATA,
    output logic [15:0] VALUE,
    output logic        VALUE_VALID,
    output logic        VALUE_CHANGED,
    output logic        PAT_ERR,
    output logic        STALE
);

    localparam logic [7:0]  SETTLE_MAX  = 8'(SETTLE);
    localparam logic [31:0] TIMEOUT_MAX = 32'(TIMEOUT);

    logic [3:0]  com_q;
    logic [7:0]  data_q;
    logic [7:0]  settleCnt_q, settleCnt_d;
    logic        capture_q, capture_d;
    logic [3:0]  seen_q, seen_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] value_q, value_d;
    logic        valid_q, valid_d;
    logic        changed_q, changed_d;
    logic        patErr_q, patErr_d;
    logic        stale_q, stale_d;
    logic [31:0] timeoutCnt_q, timeoutCnt_d;

    logic        inputsStable;
    logic        strobedCapture;
    logic        decValid;
    logic [3:0]  decDigit;
    logic [3:0]  seenNext;

    // Exact 8-bit match against the ten legal digit patterns (dp must be off).
    function automatic logic [4:0] decodeSegments(input logic [7:0] seg);
        logic [4:0] result;
        case (seg)
            8'b0000_0011: result = {1'b1, 4'd0};
            8'b1001_1111: result = {1'b1, 4'd1};
            8'b0010_0101: result = {1'b1, 4'd2};
            8'b0000_1101: result = {1'b1, 4'd3};
            8'b1001_1001: result = {1'b1, 4'd4};
            8'b0100_1001: result = {1'b1, 4'd5};
            8'b0100_0001: result = {1'b1, 4'd6};
            8'b0001_1011: result = {1'b1, 4'd7};
            8'b0000_0001: result = {1'b1, 4'd8};
            8'b0000_1001: result = {1'b1, 4'd9};
            default:      result = {1'b0, 4'd0};
        endcase
        return result;
    endfunction

    // Settle counter: counts edges on which the bus matches the previous
    // sample. The capture pulse is raised only on the step into SETTLE, so a
    // digit held indefinitely is captured exactly once.
    always_comb begin
        inputsStable = (FND_COM == com_q) && (FND_DATA == data_q);
        settleCnt_d  = 8'd0;
        capture_d    = 1'b0;
        if (inputsStable) begin
            if (settleCnt_q == SETTLE_MAX) begin
                settleCnt_d = settleCnt_q;
            end else begin
                settleCnt_d = settleCnt_q + 8'd1;
                capture_d   = (settleCnt_q == SETTLE_MAX - 8'd1);
            end
        end
    end

    // Frame assembly, error reporting and staleness tracking, all acting on
    // the registered capture pulse and the sample it refers to.
    always_comb begin
        {decValid, decDigit} = decodeSegments(data_q);
        strobedCapture = capture_q && $onehot(com_q);

        shadow_d      = shadow_q;
        seen_d        = seen_q;
        seenNext      = seen_q | com_q;
        value_d       = value_q;
        valid_d       = 1'b0;
        changed_d     = 1'b0;
        patErr_d      = 1'b0;
        stale_d       = stale_q;
        timeoutCnt_d  = timeoutCnt_q;

        if (strobedCapture) begin
            if (decValid) begin
                for (int i = 0; i < 4; i++) begin
                    if (com_q[i]) begin
                        shadow_d[i*4 +: 4] = decDigit;
                    end
                end
                if (seenNext == 4'hF) begin
                    value_d   = shadow_d;
                    valid_d   = 1'b1;
                    changed_d = (shadow_d != value_q);
                    seen_d    = 4'h0;
                end else begin
                    seen_d    = seenNext;
                end
            end else begin
                // Shadow digits are kept; only the partial scan is abandoned.
                patErr_d = 1'b1;
                seen_d   = 4'h0;
            end
        end

        // Captures with a bad strobe do not count as bus activity.
        if (strobedCapture) begin
            timeoutCnt_d = 32'd0;
        end else if (timeoutCnt_q != TIMEOUT_MAX) begin
            timeoutCnt_d = timeoutCnt_q + 32'd1;
        end

        // STALE is sticky until a whole frame arrives, not just one digit.
        if (valid_d) begin
            stale_d = 1'b0;
        end else if (timeoutCnt_d == TIMEOUT_MAX) begin
            stale_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            com_q        <= 4'h0;
            data_q       <= 8'h00;
            settleCnt_q  <= 8'd0;
            capture_q    <= 1'b0;
            seen_q       <= 4'h0;
            shadow_q     <= 16'h0000;
            value_q      <= 16'h0000;
            valid_q      <= 1'b0;
            changed_q    <= 1'b0;
            patErr_q     <= 1'b0;
            stale_q      <= 1'b0;
            timeoutCnt_q <= 32'd0;
        end else begin
            com_q        <= FND_COM;
            data_q       <= FND_DATA;
            settleCnt_q  <= settleCnt_d;
            capture_q    <= capture_d;
            seen_q       <= seen_d;
            shadow_q     <= shadow_d;
            value_q      <= value_d;
            valid_q      <= valid_d;
            changed_q    <= changed_d;
            patErr_q     <= patErr_d;
            stale_q      <= stale_d;
            timeoutCnt_q <= timeoutCnt_d;
        end
    end

    assign VALUE         = value_q;
    assign VALUE_VALID   = valid_q;
    assign VALUE_CHANGED = changed_q;
    assign PAT_ERR       = patErr_q;
    assign STALE         = stale_q;

endmodule

// File: tb/tb_fnd_capture.sv
// ---------------------------------------------------------------------------
// tb_fnd_capture
//
// Drives the FND bus with held digits and compares the monitor's outputs
// against a frame-level model of the display protocol.
// ---------------------------------------------------------------------------
module tb_fnd_capture;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 100;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [3:0]  FND_COM = 4'h0;
    logic [7:0]  FND_DATA = 8'hFF;
    logic [15:0] VALUE;
    logic        VALUE_VALID;
    logic        VALUE_CHANGED;
    logic        PAT_ERR;
    logic        STALE;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: shadow digits, seen mask and last frame.
    logic [15:0] mShadow = 16'h0;
    logic [15:0] mValue  = 16'h0;
    logic [3:0]  mSeen   = 4'h0;
    logic [11:0] prevIn  = 12'h0FF;
    int obsV, obsC, obsP, expV, expC, expP;

    logic [7:0] segTable [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                  8'h49, 8'h41, 8'h1B, 8'h01, 8'h09};

    fnd_capture #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .FND_COM(FND_COM),
        .FND_DATA(FND_DATA),
        .VALUE(VALUE),
        .VALUE_VALID(VALUE_VALID),
        .VALUE_CHANGED(VALUE_CHANGED),
        .PAT_ERR(PAT_ERR),
        .STALE(STALE)
    );

    // Free-running clock.
    always #5 CLK = ~CLK;

    // Last-resort guard so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int lookupDigit(input logic [7:0] seg);
        for (int i = 0; i < 10; i++) begin
            if (segTable[i] == seg) return i;
        end
        return -1;
    endfunction

    // What a settled digit does to the frame, from the protocol rules.
    task automatic modelCapture(input logic [3:0] com, input logic [7:0] seg);
        int d;
        int idx;
        if ($countones(com) != 1) return;
        d = lookupDigit(seg);
        if (d < 0) begin
            expP++;
            mSeen = 4'h0;
            return;
        end
        idx = 0;
        for (int i = 0; i < 4; i++) if (com[i]) idx = i;
        mShadow[idx*4 +: 4] = 4'(d);
        mSeen = mSeen | com;
        if (mSeen == 4'hF) begin
            expV++;
            if (mShadow != mValue) expC++;
            mValue = mShadow;
            mSeen  = 4'h0;
        end
    endtask

    task automatic zeroCounts();
        obsV = 0; obsC = 0; obsP = 0;
        expV = 0; expC = 0; expP = 0;
    endtask

    // Hold one bus value for a number of cycles, counting output pulses.
    task automatic applyStimulus(input logic [3:0] com, input logic [7:0] seg, input int cycles);
        FND_COM  = com;
        FND_DATA = seg;
        if (cycles >= SETTLE + 2 && {com, seg} != prevIn) modelCapture(com, seg);
        prevIn = {com, seg};
        repeat (cycles) begin
            @(negedge CLK);
            if (VALUE_VALID === 1'b1) obsV++;
            if (VALUE_CHANGED === 1'b1) obsC++;
            if (PAT_ERR === 1'b1) obsP++;
        end
    endtask

    task automatic scanValue(input logic [15:0] v);
        for (int d = 3; d >= 0; d--) begin
            applyStimulus(4'(1 << d), segTable[v[d*4 +: 4]], 10);
        end
    endtask

    task automatic assertReset();
        RESET    = 1'b1;
        FND_COM  = 4'h0;
        FND_DATA = 8'hFF;
        prevIn   = 12'h0FF;
        mShadow  = 16'h0;
        mValue   = 16'h0;
        mSeen    = 4'h0;
        zeroCounts();
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset();
        assertReset();
        vectors++; if (VALUE !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_value: got %h expected 0000", VALUE); end
        vectors++; if (VALUE_VALID !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b expected 0", VALUE_VALID); end
        vectors++; if (VALUE_CHANGED !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_changed: got %b expected 0", VALUE_CHANGED); end
        vectors++; if (PAT_ERR !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_paterr: got %b expected 0", PAT_ERR); end
        vectors++; if (STALE !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stale: got %b expected 0", STALE); end
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        vectors++; if (VALUE !== 16'h0) begin miscompares++; $display("[TB] FAIL post_reset_value: got %h expected 0000", VALUE); end
    endtask

    task automatic test_basic_scan();
        zeroCounts();
        scanValue(16'h3456);
        vectors++; if (VALUE !== mValue) begin miscompares++; $display("[TB] FAIL scan1_value: got %h expected %h", VALUE, mValue); end
        vectors++; if (obsV != expV) begin miscompares++; $display("[TB] FAIL scan1_valid_count: got %0d expected %0d", obsV, expV); end
        vectors++; if (obsC != expC) begin miscompares++; $display("[TB] FAIL scan1_changed_count: got %0d expected %0d", obsC, expC); end
        zeroCounts();
        scanValue(16'h3456);
        vectors++; if (obsV != expV) begin miscompares++; $display("[TB] FAIL scan2_valid_count: got %0d expected %0d", obsV, expV); end
        vectors++; if (obsC != expC) begin miscompares++; $display("[TB] FAIL scan2_changed_count: got %0d expected %0d", obsC, expC); end
    endtask

    task automatic test_glitch();
        zeroCounts();
        applyStimulus(4'b1000, segTable[1], 10);
        applyStimulus(4'b0100, segTable[2], 10);
        applyStimulus(4'b0010, 8'b0000_0001, 3);
        applyStimulus(4'b0010, 8'b0000_1001, 10);
        applyStimulus(4'b0001, segTable[4], 10);
        vectors++; if (VALUE !== mValue) begin miscompares++; $display("[TB] FAIL glitch_value: got %h expected %h", VALUE, mValue); end
        vectors++; if (VALUE[7:4] !== 4'd9) begin miscompares++; $display("[TB] FAIL glitch_tens: got %0d expected 9", VALUE[7:4]); end
        vectors++; if (obsP != expP) begin miscompares++; $display("[TB] FAIL glitch_paterr_count: got %0d expected %0d", obsP, expP); end
        vectors++; if (obsV != expV) begin miscompares++; $display("[TB] FAIL glitch_valid_count: got %0d expected %0d", obsV, expV); end
    endtask

    task automatic test_pat_err();
        zeroCounts();
        applyStimulus(4'b1000, segTable[7], 10);
        applyStimulus(4'b0001, segTable[1], 10);
        applyStimulus(4'b0100, 8'hFF, 10);
        vectors++; if (obsP != expP) begin miscompares++; $display("[TB] FAIL paterr_count: got %0d expected %0d", obsP, expP); end
        applyStimulus(4'b0100, segTable[0], 10);
        applyStimulus(4'b0010, segTable[2], 10);
        vectors++; if (obsV != expV) begin miscompares++; $display("[TB] FAIL paterr_partial_valid: got %0d expected %0d", obsV, expV); end
        scanValue(16'h7021);
        vectors++; if (obsV != expV) begin miscompares++; $display("[TB] FAIL paterr_rescan_valid: got %0d expected %0d", obsV, expV); end
        vectors++; if (VALUE !== mValue) begin miscompares++; $display("[TB] FAIL paterr_rescan_value: got %h expected %h", VALUE, mValue); end
    endtask

    task automatic test_bad_strobe();
        zeroCounts();
        applyStimulus(4'b0000, segTable[5], 20);
        applyStimulus(4'b1100, segTable[5], 20);
        vectors++; if (obsV != expV) begin miscompares++; $display("[TB] FAIL strobe_valid_count: got %0d expected %0d", obsV, expV); end
        vectors++; if (obsP != expP) begin miscompares++; $display("[TB] FAIL strobe_paterr_count: got %0d expected %0d", obsP, expP); end
        vectors++; if (VALUE !== mValue) begin miscompares++; $display("[TB] FAIL strobe_value: got %h expected %h", VALUE, mValue); end
    endtask

    task automatic test_reset_midframe();
        zeroCounts();
        applyStimulus(4'b1000, segTable[9], 10);
        applyStimulus(4'b0100, segTable[8], 10);
        applyStimulus(4'b0010, segTable[3], 10);
        assertReset();
        vectors++; if (VALUE !== 16'h0) begin miscompares++; $display("[TB] FAIL midreset_value: got %h expected 0000", VALUE); end
        vectors++; if ({VALUE_VALID, VALUE_CHANGED, PAT_ERR, STALE} !== 4'b0) begin miscompares++; $display("[TB] FAIL midreset_flags: got %b expected 0000", {VALUE_VALID, VALUE_CHANGED, PAT_ERR, STALE}); end
        RESET = 1'b0;
        @(negedge CLK);
        applyStimulus(4'b0001, segTable[6], 10);
        vectors++; if (obsV != expV) begin miscompares++; $display("[TB] FAIL midreset_valid_count: got %0d expected %0d", obsV, expV); end
        vectors++; if (VALUE !== mValue) begin miscompares++; $display("[TB] FAIL midreset_after_value: got %h expected %h", VALUE, mValue); end
    endtask

    task automatic test_random();
        logic [3:0] com;
        logic [7:0] seg;
        int cycles;
        for (int n = 0; n < 24; n++) begin
            do begin
                com = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'(1 << $urandom_range(0, 3));
                seg = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : segTable[$urandom_range(0, 9)];
            end while ({com, seg} == prevIn);
            cycles = ($urandom_range(0, 4) == 0) ? 3 : 10;
            zeroCounts();
            applyStimulus(com, seg, cycles);
            vectors++; if (obsV != expV) begin miscompares++; $display("[TB] FAIL rand%0d_valid: got %0d expected %0d", n, obsV, expV); end
            vectors++; if (obsC != expC) begin miscompares++; $display("[TB] FAIL rand%0d_changed: got %0d expected %0d", n, obsC, expC); end
            vectors++; if (obsP != expP) begin miscompares++; $display("[TB] FAIL rand%0d_paterr: got %0d expected %0d", n, obsP, expP); end
            vectors++; if (VALUE !== mValue) begin miscompares++; $display("[TB] FAIL rand%0d_value: got %h expected %h", n, VALUE, mValue); end
        end
    endtask

    task automatic test_stale();
        assertReset();
        RESET = 1'b0;
        repeat (TIMEOUT - 1) @(negedge CLK);
        vectors++; if (STALE !== 1'b0) begin miscompares++; $display("[TB] FAIL stale_early: got %b expected 0", STALE); end
        @(negedge CLK);
        vectors++; if (STALE !== 1'b1) begin miscompares++; $display("[TB] FAIL stale_at_timeout: got %b expected 1", STALE); end
        applyStimulus(4'b1000, segTable[2], 10);
        vectors++; if (STALE !== 1'b1) begin miscompares++; $display("[TB] FAIL stale_single_capture: got %b expected 1", STALE); end
        scanValue(16'h0789);
        vectors++; if (STALE !== 1'b0) begin miscompares++; $display("[TB] FAIL stale_after_frame: got %b expected 0", STALE); end
        vectors++; if (obsV != expV) begin miscompares++; $display("[TB] FAIL stale_frame_valid: got %0d expected %0d", obsV, expV); end
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_basic_scan();
        test_glitch();
        test_pat_err();
        test_bad_strobe();
        test_reset_midframe();
        test_random();
        test_stale();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
